pipe_stall_ctrl: RTL

Pipeline interlock scheduler for the five-stage core (IF, ID, EX, MEM, WB). It consumes the register-file forwarding hazard flags, load-in-stage flags, bus stalls, multicycle-op start and exception flush. From these it produces per-stage stall and flush vectors. It owns the multicycle-unit (divider) occupancy FSM and countdown, so the register file's ID-stage operands are never read stale.

---
 rtl/pipe_stall_ctrl_pkg.sv | 46 ++++
 rtl/pipe_stall_ctrl_mc_timer.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline interlock scheduler: stage indices,
// the stall/flush vector for each priority level, and the multicycle FSM
// state encodings.
package pipe_stall_ctrl_pkg;

  // Stage indices into the stall/flush vectors
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NSTG    = 5;

  // Exception/ERET commit: every stage up to MEM is squashed, nothing holds
  localparam logic [NSTG-1:0] STALL_EXC  = 5'b00000;
  localparam logic [NSTG-1:0] FLUSH_EXC  = 5'b01111;
  // Data bus wait: IF..MEM hold, WB receives a bubble
  localparam logic [NSTG-1:0] STALL_DBUS = 5'b01111;
  localparam logic [NSTG-1:0] FLUSH_DBUS = 5'b10000;
  // Multicycle op occupying EX: IF..EX hold, MEM receives a bubble
  localparam logic [NSTG-1:0] STALL_MC   = 5'b00111;
  localparam logic [NSTG-1:0] FLUSH_MC   = 5'b01000;
  // Load-use interlock: IF/ID hold, EX receives a bubble
  localparam logic [NSTG-1:0] STALL_LU   = 5'b00011;
  localparam logic [NSTG-1:0] FLUSH_LU   = 5'b00100;
  // Instruction fetch wait: IF holds, ID receives a bubble
  localparam logic [NSTG-1:0] STALL_IBUS = 5'b00001;
  localparam logic [NSTG-1:0] FLUSH_IBUS = 5'b00010;
  // Free-running pipeline
  localparam logic [NSTG-1:0] STALL_NONE = 5'b00000;
  localparam logic [NSTG-1:0] FLUSH_NONE = 5'b00000;

  // Multicycle unit occupancy states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MC   = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Stall and flush travel together out of the priority resolver
  typedef struct packed {
    logic [NSTG-1:0] stall;
    logic [NSTG-1:0] flush;
  } ctl_vec_t;

endpackage

// File: rtl/pipe_stall_ctrl_mc_timer.sv
// Loadable down-counter tracking the remaining cycles of a multicycle op.
// Abort wins over load, load wins over decrement; the count saturates at 0.
module mc_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_abort,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Countdown register: cleared by reset or abort, reloaded on op start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock scheduler for the five-stage core. Resolves exception
// flush, bus waits, multicycle occupancy, load-use hazards and fetch waits
// into per-stage stall/flush vectors, and owns the divider occupancy FSM.
// Optional feature macro: STALL_PERF_EN (stalled-cycle counter on perf_stall).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_LAT = 32,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hazard_ex,
  input  logic          ex_isload,
  input  logic          hazard_mem,
  input  logic          mem_isload,
  input  logic          mc_start,
  input  logic          ibus_stall,
  input  logic          dbus_stall,
  input  logic          exc_flush,
  output logic [4:0]    stall,
  output logic [4:0]    flush,
  output logic          mc_busy,
  output logic          mc_done,
  output logic [CW-1:0] mc_cnt,
  output logic [31:0]   perf_stall
);

  localparam logic [CW-1:0] LP_LOAD_VAL = CW'(MC_LAT - 1);

  mc_state_t     r_state;
  logic          w_load_use;
  logic          w_mc_load;
  logic          w_mc_abort;
  logic          w_mc_dec;
  logic          w_cnt_zero;
  logic [CW-1:0] w_cnt;
  ctl_vec_t      w_ctl;

  // A load producing an operand ID needs cannot be forwarded in time;
  // non-load matches are covered by the forwarding network.
  assign w_load_use = (hazard_ex & ex_isload) | (hazard_mem & mem_isload);

  // Timer control: start only from RUN, and an exception aborts any op,
  // including one trying to start in the same cycle.
  assign w_mc_abort = exc_flush;
  assign w_mc_load  = (r_state == ST_RUN) && mc_start && !exc_flush;
  assign w_mc_dec   = (r_state == ST_MC);

  mc_timer #(
    .CW (CW)
  ) u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mc_load),
    .i_load_val (LP_LOAD_VAL),
    .i_abort    (w_mc_abort),
    .i_dec      (w_mc_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Occupancy FSM: RUN -> MC for MC_LAT cycles -> DONE for one result cycle
  // (stretched while the data bus stalls) -> RUN. Exception returns to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else if (exc_flush) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (mc_start)    r_state <= ST_MC;
        ST_MC:   if (w_cnt_zero)  r_state <= ST_DONE;
        ST_DONE: if (!dbus_stall) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Priority resolver; reset forces a quiet pipeline regardless of inputs.
  // DONE deliberately falls through: EX captures the result that cycle.
  always_comb begin
    w_ctl.stall = STALL_NONE;
    w_ctl.flush = FLUSH_NONE;
    if (!rst) begin
      w_ctl.stall = STALL_NONE;
      w_ctl.flush = FLUSH_NONE;
    end else if (exc_flush) begin
      w_ctl.stall = STALL_EXC;
      w_ctl.flush = FLUSH_EXC;
    end else if (dbus_stall) begin
      w_ctl.stall = STALL_DBUS;
      w_ctl.flush = FLUSH_DBUS;
    end else if (r_state == ST_MC) begin
      w_ctl.stall = STALL_MC;
      w_ctl.flush = FLUSH_MC;
    end else if (w_load_use) begin
      w_ctl.stall = STALL_LU;
      w_ctl.flush = FLUSH_LU;
    end else if (ibus_stall) begin
      w_ctl.stall = STALL_IBUS;
      w_ctl.flush = FLUSH_IBUS;
    end
  end

  assign stall   = w_ctl.stall;
  assign flush   = w_ctl.flush;
  assign mc_busy = (r_state != ST_RUN);
  assign mc_done = (r_state == ST_DONE);
  assign mc_cnt  = w_cnt;

`ifdef STALL_PERF_EN
  logic [31:0] r_perf_stall;

  // Count every cycle the ID stage is held; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
    end else if (w_ctl.stall[STG_ID]) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall = r_perf_stall;
`else
  assign perf_stall = '0;
`endif

endmodule
